// File: rtl/pipe_addsub.sv
// pipe_addsub: chunked ripple add/subtract pipeline with valid/ready flow control
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic              en;
    logic [STAGES-1:0] v_q, v_d, c_q, c_d, sa_q, sa_d, sb_q, sb_d;
    logic [STAGES-1:0] vi, ci, sai, sbi;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];
    logic [WIDTH-1:0]  r_d [STAGES];
    logic [WIDTH-1:0]  si  [STAGES];
    logic [WIDTH-1:0]  ri  [STAGES];
    logic [CW:0]       t;

    assign in_ready  = en;
    assign out_valid = v_q[L];
    assign Sum       = s_q[L];
    assign Cout      = c_q[L];
    assign Ovf       = (sa_q[L] == sb_q[L]) && (s_q[L][WIDTH-1] != sa_q[L]);

    // s words carry finished sum chunks low and untouched a chunks high; r words keep the next effective-b chunk in the low bits
    always_comb begin
        en     = !v_q[L] || out_ready;
        si[0]  = a;
        ri[0]  = b ^ {WIDTH{sub}};
        ci[0]  = cin ^ sub;
        vi[0]  = in_valid;
        sai[0] = a[WIDTH-1];
        sbi[0] = b[WIDTH-1] ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            si[k]  = s_q[k-1];
            ri[k]  = r_q[k-1];
            ci[k]  = c_q[k-1];
            vi[k]  = v_q[k-1];
            sai[k] = sa_q[k-1];
            sbi[k] = sb_q[k-1];
        end
        t = '0;
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, si[k][k*CW +: CW]} + {1'b0, ri[k][CW-1:0]} + {{CW{1'b0}}, ci[k]};
            s_d[k] = si[k];
            s_d[k][k*CW +: CW] = t[CW-1:0];
            c_d[k]  = t[CW];
            r_d[k]  = ri[k] >> CW;
            v_d[k]  = vi[k];
            sa_d[k] = sai[k];
            sb_d[k] = sbi[k];
        end
    end

    // whole pipeline shifts together when the output slot is free or being drained, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q  <= '0;
            c_q  <= '0;
            sa_q <= '0;
            sb_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (en) begin
            v_q  <= v_d;
            c_q  <= c_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            s_q  <= s_d;
            r_q  <= r_d;
        end
    end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: randomized and directed checks of pipe_addsub against an arithmetic reference model
module tb_pipe_addsub;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, Cout, Ovf;
    logic [7:0] a, b, Sum;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] q [$];
    bit         hold = 1'b0;
    logic [9:0] held = '0;

    pipe_addsub #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {Ovf, Cout, Sum} from plain integer arithmetic
    function automatic logic [9:0] model(logic [7:0] x, logic [7:0] y, logic c, logic s);
        int u, v;
        logic [7:0] sm;
        logic co, ov;
        u  = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
        v  = s ? int'($signed(x)) - int'($signed(y)) - int'(c)
               : int'($signed(x)) + int'($signed(y)) + int'(c);
        sm = u[7:0];
        co = s ? (u >= 0) : (u > 255);
        ov = (v > 127) || (v < -128);
        return {ov, co, sm};
    endfunction

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // scoreboard: order, values, no stale results, stability under back-pressure
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) chk("hold_stable", 32'({out_valid, Ovf, Cout, Sum}), 32'({1'b1, held}));
            if (out_valid) begin
                chk("no_stale", 32'(q.size() != 0), 32'(1));
                if (out_ready && q.size() != 0) chk("result", 32'({Ovf, Cout, Sum}), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            hold = out_valid && !out_ready;
            held = {Ovf, Cout, Sum};
        end
    end

    task automatic beat(string nm, logic [7:0] x, logic [7:0] y, logic c, logic s,
                        logic [7:0] es, logic ec, logic eo);
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({nm, "_early"}, 32'(out_valid), 32'(0));
        step();
        chk({nm, "_valid"}, 32'(out_valid), 32'(1));
        chk({nm, "_sum"}, 32'(Sum), 32'(es));
        chk({nm, "_cout"}, 32'(Cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(Ovf), 32'(eo));
        step();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         acc;
        int         i, n, sent;
        logic [7:0] got [4];
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_sum", 32'(Sum), 32'(0));
        chk("reset_cout", 32'(Cout), 32'(0));
        chk("reset_ovf", 32'(Ovf), 32'(0));
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        chk("model_sub", 32'(model(8'h05, 8'h0D, 1'b1, 1'b1)), 32'({1'b0, 1'b0, 8'hF7}));
        chk("model_ovf", 32'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 32'({1'b1, 1'b0, 8'h80}));
        chk("model_subovf", 32'(model(8'h80, 8'h01, 1'b0, 1'b1)), 32'({1'b1, 1'b1, 8'h7F}));
        beat("add",     8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        beat("carry",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        beat("sub_brw", 8'h05, 8'h0D, 1'b1, 1'b1, 8'hF7, 1'b0, 1'b0);
        beat("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        i = 0; n = 0; out_ready = 1'b0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (c == 5) out_ready = 1'b1;
            in_valid = (i < 4); a = 8'((i + 1) * 16); b = 8'(i + 1); cin = 1'b0; sub = 1'b0;
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                chk("bp_sum_hold", 32'(Sum), 32'h11);
                chk("bp_in_ready", 32'(in_ready), 32'(0));
            end
            if (out_valid && out_ready && n < 4) begin
                got[n] = Sum;
                n++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("bp_count", 32'(n), 32'(4));
        for (int k = 0; k < 4; k++) chk("bp_order", 32'(got[k]), 32'((k + 1) * 8'h11));
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h21; b = 8'h12;
        step();
        a = 8'h34; b = 8'h43;
        step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(Sum), 32'(0));
        for (int c = 0; c < 5; c++) begin
            chk("rst_no_stale", 32'(out_valid), 32'(0));
            step();
        end
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        chk("rand_sent", 32'(sent), 32'(1000));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        chk("drain_empty", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the number of pipeline stages; WIDTH mod STAGES SHALL be 0, and CW = WIDTH/STAGES SHALL be the chunk width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (add) or borrow-in (sub).
REQ-011 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 Sum  output  WIDTH  result.
REQ-015 Cout  output  1  carry-out; in sub mode 1 = no borrow.
REQ-016 Ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Add mode SHALL compute {Cout,Sum} = a + b + cin; sub mode SHALL compute {Cout,Sum} = a + ~b + ~cin, i.e. Sum = a - b - cin mod 2^WIDTH.
REQ-018 Ovf SHALL be 1 iff the operand sign bits (a, effective b) are equal and Sum's MSB differs from them.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k, bits [k*CW +: CW], with the carry registered from stage k-1; stage 0 SHALL use the effective carry-in.
REQ-020 Upper chunks of a, effective b and mode SHALL be carried forward in registers alongside their beat; lower-chunk partial sums SHALL be held until the beat exits.
REQ-021 Each stage SHALL hold a valid bit; global advance en = !out_valid || out_ready.
REQ-022 in_ready SHALL equal en; a beat SHALL be accepted when in_valid && in_ready.
REQ-023 When en = 1, every stage SHALL shift forward one position; stage 0 SHALL load the accepted beat or a bubble (valid 0).
REQ-024 When en = 0, all stage registers, Sum, Cout, Ovf and out_valid SHALL hold.
REQ-025 Latency SHALL be exactly STAGES cycles from acceptance to out_valid under no back-pressure; throughput SHALL be one beat per cycle.
REQ-026 Results SHALL exit in acceptance order; no beat SHALL be dropped or duplicated under any out_ready pattern.
REQ-027 Sum, Cout and Ovf SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-028 Bubbles SHALL NOT be collapsed; they advance like beats.
REQ-029 Simultaneous output handshake and input acceptance SHALL both complete in the same cycle.

Reset
REQ-030 While rst_n = 0 at a clk edge, all stage valids and out_valid SHALL clear to 0, and Sum, Cout and Ovf SHALL clear to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; no result for them SHALL appear after reset.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Verification (WIDTH=8, STAGES=2, CW=4)
REQ-033 Add: a=0x01, b=0x02, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, Sum=0x03, Cout=0, Ovf=0.
REQ-034 Cross-chunk carry: a=0xFF, b=0x01, cin=0, sub=0 -> Sum=0x00, Cout=1, Ovf=0; a=0x7F, b=0x01 -> Sum=0x80, Cout=0, Ovf=1.
REQ-035 Subtract: a=0x05, b=0x0D, cin=1, sub=1 -> Sum=0xF7, Cout=0 (borrow), Ovf=0; a=0x80, b=0x01, cin=0, sub=1 -> Sum=0x7F, Cout=1, Ovf=1.
REQ-036 Back-pressure: stream 4 back-to-back beats (0x10+0x01, 0x20+0x02, 0x30+0x03, 0x40+0x04) with out_ready=0 for 5 cycles -> in_ready drops once out_valid=1, output holds 0x11; on out_ready=1 the bench reads 0x11, 0x22, 0x33, 0x44 in order, none lost.
REQ-037 Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle -> out_valid=0, Sum=0x00 from the next edge; no stale result ever appears.
REQ-038 Random: 1000 random beats with random sub, cin and out_ready, checked against a reference model -> all results match, order preserved.
